// File: rtl/fb_rect_arbiter.sv
// fb_rect_arbiter: write-side controller for the 160x120, 3-bit image RAM.
// Two requesters submit rectangle fills; they are served round-robin and
// each rectangle is clipped to the screen and written one pixel per clock
// in raster order through we/xw/yw/din.
// Optional feature macro: FB_CLEAR_ON_RESET_EN -- after every reset the whole
// screen is filled with CLEAR_COLOR before any command is accepted.
module fb_rect_arbiter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
`ifdef FB_CLEAR_ON_RESET_EN
  ,
  parameter logic [2:0] CLEAR_COLOR = 3'b000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] x0_0,
  input  logic [7:0] x0_1,
  input  logic [6:0] y0_0,
  input  logic [6:0] y0_1,
  input  logic [7:0] w_0,
  input  logic [7:0] w_1,
  input  logic [6:0] h_0,
  input  logic [6:0] h_1,
  input  logic [2:0] color_0,
  input  logic [2:0] color_1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       busy,
  output logic       we,
  output logic [7:0] xw,
  output logic [6:0] yw,
  output logic [2:0] din
);

`ifdef FB_CLEAR_ON_RESET_EN
  typedef enum logic [1:0] {IDLE, FILL, DONE, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
`endif

  state_t     state, state_n;
  logic       last_served, last_served_n;
  logic       owner, owner_n;
  logic       active, active_n;
  logic [7:0] lx0, lx0_n;
  logic [6:0] ly0, ly0_n;
  logic [7:0] lwl, lwl_n;
  logic [6:0] lhl, lhl_n;
  logic [2:0] lcol, lcol_n;
  logic [7:0] cx, cx_n;
  logic [6:0] cy, cy_n;
  logic [1:0] grant_n, done_n;
  logic       we_n;
  logic [7:0] xw_n;
  logic [6:0] yw_n;
  logic [2:0] din_n;

  logic       sel;
  logic [7:0] sx0, sw;
  logic [6:0] sy0, sh;
  logic [2:0] scol;
  logic [8:0] w_room, h_room, w_eff, h_eff;

  assign busy = (state != IDLE);

  // Choose the requester to serve and clip its rectangle to the screen.
  always_comb begin
    sel    = (req == 2'b11) ? ~last_served : req[1];
    sx0    = sel ? x0_1    : x0_0;
    sy0    = sel ? y0_1    : y0_0;
    sw     = sel ? w_1     : w_0;
    sh     = sel ? h_1     : h_0;
    scol   = sel ? color_1 : color_0;
    w_room = 9'(SCREEN_W) - {1'b0, sx0};
    h_room = 9'(SCREEN_H) - {2'b00, sy0};
    if ({1'b0, sx0} >= 9'(SCREEN_W))
      w_eff = '0;
    else if ({1'b0, sw} < w_room)
      w_eff = {1'b0, sw};
    else
      w_eff = w_room;
    if ({2'b00, sy0} >= 9'(SCREEN_H))
      h_eff = '0;
    else if ({2'b00, sh} < h_room)
      h_eff = {2'b00, sh};
    else
      h_eff = h_room;
  end

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_n       = state;
    last_served_n = last_served;
    owner_n       = owner;
    active_n      = active;
    lx0_n         = lx0;
    ly0_n         = ly0;
    lwl_n         = lwl;
    lhl_n         = lhl;
    lcol_n        = lcol;
    cx_n          = cx;
    cy_n          = cy;
    grant_n       = '0;
    done_n        = '0;
    we_n          = 1'b0;
    xw_n          = xw;
    yw_n          = yw;
    din_n         = din;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_n       = sel ? 2'b10 : 2'b01;
          last_served_n = sel;
          owner_n       = sel;
          lx0_n         = sx0;
          ly0_n         = sy0;
          lcol_n        = scol;
          lwl_n         = 8'(w_eff - 9'd1);
          lhl_n         = 7'(h_eff - 9'd1);
          cx_n          = '0;
          cy_n          = '0;
          // An empty rectangle enters FILL with nothing pending, so done
          // follows grant by exactly one cycle and no write is issued.
          active_n      = (w_eff != '0) && (h_eff != '0);
          state_n       = FILL;
        end
      end
      FILL: begin
        if (active) begin
          we_n  = 1'b1;
          xw_n  = lx0 + cx;
          yw_n  = ly0 + cy;
          din_n = lcol;
          if (cx == lwl) begin
            cx_n = '0;
            if (cy == lhl)
              active_n = 1'b0;
            else
              cy_n = cy + 7'd1;
          end else begin
            cx_n = cx + 8'd1;
          end
        end else begin
          done_n  = owner ? 2'b10 : 2'b01;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
`ifdef FB_CLEAR_ON_RESET_EN
      CLEAR: begin
        if (active) begin
          we_n  = 1'b1;
          xw_n  = cx;
          yw_n  = cy;
          din_n = CLEAR_COLOR;
          if (cx == 8'(SCREEN_W - 1)) begin
            cx_n = '0;
            if (cy == 7'(SCREEN_H - 1)) begin
              cy_n     = '0;
              active_n = 1'b0;
            end else begin
              cy_n = cy + 7'd1;
            end
          end else begin
            cx_n = cx + 8'd1;
          end
        end else begin
          state_n = IDLE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, command latch, raster counters and registered RAM-port outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
`ifdef FB_CLEAR_ON_RESET_EN
      state  <= CLEAR;
      active <= 1'b1;
`else
      state  <= IDLE;
      active <= 1'b0;
`endif
      last_served <= 1'b1;
      owner       <= 1'b0;
      lx0         <= '0;
      ly0         <= '0;
      lwl         <= '0;
      lhl         <= '0;
      lcol        <= '0;
      cx          <= '0;
      cy          <= '0;
      grant       <= '0;
      done        <= '0;
      we          <= 1'b0;
      xw          <= '0;
      yw          <= '0;
      din         <= '0;
    end else begin
      state       <= state_n;
      active      <= active_n;
      last_served <= last_served_n;
      owner       <= owner_n;
      lx0         <= lx0_n;
      ly0         <= ly0_n;
      lwl         <= lwl_n;
      lhl         <= lhl_n;
      lcol        <= lcol_n;
      cx          <= cx_n;
      cy          <= cy_n;
      grant       <= grant_n;
      done        <= done_n;
      we          <= we_n;
      xw          <= xw_n;
      yw          <= yw_n;
      din         <= din_n;
    end
  end

endmodule

// File: tb/tb_fb_rect_arbiter.sv
// Self-checking bench for fb_rect_arbiter; expected pixel streams are built
// from the clipping rule and raster order, grant order from round-robin.
module tb_fb_rect_arbiter;

  localparam int SW = 160;
  localparam int SH = 120;
`ifdef FB_CLEAR_ON_RESET_EN
  localparam logic BUSY_AFTER_RESET = 1'b1;
`else
  localparam logic BUSY_AFTER_RESET = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = '0;
  logic [7:0] x0_0 = '0, x0_1 = '0, w_0 = '0, w_1 = '0;
  logic [6:0] y0_0 = '0, y0_1 = '0, h_0 = '0, h_1 = '0;
  logic [2:0] color_0 = '0, color_1 = '0;
  logic [1:0] grant, done;
  logic       busy, we;
  logic [7:0] xw;
  logic [6:0] yw;
  logic [2:0] din;

  int checks = 0;
  int errors = 0;
  int m_last = 1;

  fb_rect_arbiter #(
    .SCREEN_W(SW),
`ifdef FB_CLEAR_ON_RESET_EN
    .CLEAR_COLOR(3'b111),
`endif
    .SCREEN_H(SH)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req(req),
    .x0_0(x0_0), .x0_1(x0_1), .y0_0(y0_0), .y0_1(y0_1),
    .w_0(w_0), .w_1(w_1), .h_0(h_0), .h_1(h_1),
    .color_0(color_0), .color_1(color_1),
    .grant(grant), .done(done), .busy(busy), .we(we),
    .xw(xw), .yw(yw), .din(din)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int clip(input int org, input int len, input int lim);
    if (org >= lim) return 0;
    return (len < lim - org) ? len : lim - org;
  endfunction

  function automatic logic [1:0] oh(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_cmd(input int r, input int x, input int y, input int w, input int h, input int c);
    if (r == 0) begin
      x0_0 = 8'(x); y0_0 = 7'(y); w_0 = 8'(w); h_0 = 7'(h); color_0 = 3'(c);
    end else begin
      x0_1 = 8'(x); y0_1 = 7'(y); w_1 = 8'(w); h_1 = 7'(h); color_1 = 3'(c);
    end
  endtask

  // One command from an idle arbiter: grant timing, pixel stream, done timing.
  task automatic exec_cmd(input string tag, input int r, input int x, input int y,
                          input int w, input int h, input int c);
    int we_e, he_e, n_exp, t, t_grant, t_done, nw, ex, ey;
    we_e = clip(x, w, SW);
    he_e = clip(y, h, SH);
    n_exp = we_e * he_e;
    @(posedge CLOCK_50); #1;
    set_cmd(r, x, y, w, h, c);
    req[r] = 1'b1;
    t = 0; t_grant = -1; t_done = -1; nw = 0;
    while (t_done < 0 && t < n_exp + 20) begin
      @(negedge CLOCK_50);
      t++;
      if (grant !== 2'b00) begin
        checks++;
        if (grant !== oh(r) || t != 2 || t_grant >= 0) begin
          errors++;
          $display("FAIL %s grant: got %b at cycle %0d, want %b at cycle 2", tag, grant, t, oh(r));
        end
        t_grant = t;
      end
      if (we !== 1'b0) begin
        ex = (nw < n_exp) ? x + nw % we_e : -1;
        ey = (nw < n_exp) ? y + nw / we_e : -1;
        checks++;
        if (nw >= n_exp || xw !== 8'(ex) || yw !== 7'(ey) || din !== 3'(c) ||
            t != t_grant + 1 + nw || busy !== 1'b1) begin
          errors++;
          $display("FAIL %s write %0d: got (%0d,%0d) din=%0d busy=%b cyc=%0d, want (%0d,%0d) din=%0d busy=1 cyc=%0d (of %0d writes)",
                   tag, nw, xw, yw, din, busy, t, ex, ey, c, t_grant + 1 + nw, n_exp);
        end
        nw++;
      end
      if (done !== 2'b00) begin
        checks++;
        if (done !== oh(r) || t != t_grant + 1 + n_exp || nw != n_exp) begin
          errors++;
          $display("FAIL %s done: got %b at cycle %0d after %0d writes, want %b at cycle %0d after %0d writes",
                   tag, done, t, nw, oh(r), t_grant + 1 + n_exp, n_exp);
        end
        t_done = t;
      end
    end
    if (t_done < 0) begin
      checks++; errors++;
      $display("FAIL %s timeout: got no done within %0d cycles, want done", tag, t);
    end
    @(posedge CLOCK_50); #1;
    req[r] = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0 || grant !== 2'b00 || we !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got busy=%b grant=%b we=%b, want 0 0 0", tag, busy, grant, we);
    end
    m_last = r;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (grant !== 2'b00 || done !== 2'b00 || we !== 1'b0 || xw !== 8'd0 || yw !== 7'd0 || din !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b done=%b we=%b xw=%0d yw=%0d din=%0d, want all 0",
               grant, done, we, xw, yw, din);
    end
    checks++;
    if (busy !== BUSY_AFTER_RESET) begin
      errors++;
      $display("FAIL reset_busy: got %b, want %b", busy, BUSY_AFTER_RESET);
    end
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    m_last = 1;
  endtask

`ifdef FB_CLEAR_ON_RESET_EN
  // Full-screen clear after reset; optionally holds req1 across it.
  task automatic check_clear(input bit hold);
    int n, t, tg;
    bit got_grant, got_done;
    if (hold) begin
      set_cmd(1, 3, 4, 1, 1, 1);
      req[1] = 1'b1;
    end
    n = 0; t = 0;
    while (n < SW * SH && t < SW * SH + 20) begin
      @(negedge CLOCK_50);
      t++;
      checks++;
      if (grant !== 2'b00 || done !== 2'b00) begin
        errors++;
        $display("FAIL clear_handshake: got grant=%b done=%b at clear write %0d, want 00 00", grant, done, n);
      end
      if (we !== 1'b0) begin
        checks++;
        if (xw !== 8'(n % SW) || yw !== 7'(n / SW) || din !== 3'b111 || busy !== 1'b1) begin
          errors++;
          $display("FAIL clear_write %0d: got (%0d,%0d) din=%0d busy=%b, want (%0d,%0d) din=7 busy=1",
                   n, xw, yw, din, busy, n % SW, n / SW);
        end
        n++;
      end
    end
    checks++;
    if (n != SW * SH) begin
      errors++;
      $display("FAIL clear_count: got %0d writes, want %0d", n, SW * SH);
    end
    if (hold) begin
      got_grant = 1'b0; got_done = 1'b0; tg = 0;
      for (int k = 0; k < 12 && !got_done; k++) begin
        @(negedge CLOCK_50);
        if (grant !== 2'b00) begin
          checks++;
          got_grant = 1'b1;
          if (grant !== 2'b10) begin
            errors++;
            $display("FAIL clear_held_grant: got %b, want 10", grant);
          end
        end
        if (we !== 1'b0) begin
          checks++;
          if (xw !== 8'd3 || yw !== 7'd4 || din !== 3'd1 || !got_grant) begin
            errors++;
            $display("FAIL clear_held_write: got (%0d,%0d) din=%0d, want (3,4) din=1 after grant", xw, yw, din);
          end
        end
        if (done !== 2'b00) begin
          checks++;
          got_done = 1'b1;
          if (done !== 2'b10) begin
            errors++;
            $display("FAIL clear_held_done: got %b, want 10", done);
          end
        end
        tg++;
      end
      if (!got_done) begin
        checks++; errors++;
        $display("FAIL clear_held_timeout: got no done in %0d cycles, want grant then done", tg);
      end
      @(posedge CLOCK_50); #1;
      req[1] = 1'b0;
      @(negedge CLOCK_50);
      m_last = 1;
    end else begin
      for (int k = 0; k < 3; k++) @(negedge CLOCK_50);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL clear_end_busy: got %b, want 0", busy);
      end
    end
  endtask
`endif

  // Both requesters held high: strict alternation, one command at a time.
  task automatic test_round_robin();
    int t, ng, owner, expect_r, last_done_t;
    bit outstanding;
    set_cmd(0, 30, 40, 1, 1, 1);
    set_cmd(1, 90, 100, 1, 1, 6);
    @(posedge CLOCK_50); #1;
    req = 2'b11;
    expect_r = (m_last == 1) ? 0 : 1;
    t = 0; ng = 0; owner = 0; outstanding = 1'b0; last_done_t = -10;
    while ((ng < 4 || outstanding) && t < 100) begin
      @(negedge CLOCK_50);
      t++;
      if (grant !== 2'b00) begin
        checks++;
        if (outstanding || grant !== oh(expect_r) || t - last_done_t < 2) begin
          errors++;
          $display("FAIL rr_grant %0d: got %b busy_cmd=%0d, want %b with no command outstanding", ng, grant, outstanding, oh(expect_r));
        end
        outstanding = 1'b1;
        owner = expect_r;
        expect_r = 1 - expect_r;
        ng++;
      end
      if (we !== 1'b0) begin
        checks++;
        if (!outstanding || xw !== ((owner == 0) ? 8'd30 : 8'd90) ||
            yw !== ((owner == 0) ? 7'd40 : 7'd100) || din !== ((owner == 0) ? 3'd1 : 3'd6)) begin
          errors++;
          $display("FAIL rr_write: got (%0d,%0d) din=%0d, want pixel of requester %0d", xw, yw, din, owner);
        end
      end
      if (done !== 2'b00) begin
        checks++;
        if (!outstanding || done !== oh(owner)) begin
          errors++;
          $display("FAIL rr_done: got %b, want %b", done, oh(owner));
        end
        outstanding = 1'b0;
        last_done_t = t;
      end
    end
    if (ng < 4 || outstanding) begin
      checks++; errors++;
      $display("FAIL rr_timeout: got %0d grants, want 4 completed", ng);
    end
    @(posedge CLOCK_50); #1;
    req = 2'b00;
    @(negedge CLOCK_50);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: got grant=%b busy=%b, want 00 0", grant, busy);
    end
    m_last = owner;
  endtask

  // req1 arrives during req0's fill; req0 drops mid-fill yet completes.
  task automatic test_back_to_back();
    int ex[$], ey[$], ec[$];
    int t, nw, ng, nd, t_done0, cw, ch;
    int cx0 [2] = '{40, 70};
    int cy0 [2] = '{50, 60};
    int cwd [2] = '{3, 2};
    int cht [2] = '{2, 2};
    int ccl [2] = '{2, 6};
    for (int r = 0; r < 2; r++) begin
      cw = clip(cx0[r], cwd[r], SW);
      ch = clip(cy0[r], cht[r], SH);
      for (int j = 0; j < ch; j++)
        for (int i = 0; i < cw; i++) begin
          ex.push_back(cx0[r] + i); ey.push_back(cy0[r] + j); ec.push_back(ccl[r]);
        end
    end
    @(posedge CLOCK_50); #1;
    set_cmd(0, cx0[0], cy0[0], cwd[0], cht[0], ccl[0]);
    set_cmd(1, cx0[1], cy0[1], cwd[1], cht[1], ccl[1]);
    req[0] = 1'b1;
    t = 0; nw = 0; ng = 0; nd = 0; t_done0 = -100;
    while (nd < 2 && t < 60) begin
      @(negedge CLOCK_50);
      t++;
      if (grant !== 2'b00) begin
        checks++;
        if (ng > 1 || grant !== oh(ng) || (ng == 1 && t != t_done0 + 2)) begin
          errors++;
          $display("FAIL b2b_grant %0d: got %b at cycle %0d, want %b (done0 at %0d)", ng, grant, t, oh(ng), t_done0);
        end
        if (ng == 0) req[1] = 1'b1;
        ng++;
      end
      if (we !== 1'b0) begin
        checks++;
        if (nw >= ex.size() || xw !== 8'(ex[nw]) || yw !== 7'(ey[nw]) || din !== 3'(ec[nw])) begin
          errors++;
          $display("FAIL b2b_write %0d: got (%0d,%0d) din=%0d, want (%0d,%0d) din=%0d",
                   nw, xw, yw, din, (nw < ex.size()) ? ex[nw] : -1, (nw < ey.size()) ? ey[nw] : -1, (nw < ec.size()) ? ec[nw] : -1);
        end
        nw++;
        if (nw == 2) req[0] = 1'b0;
      end
      if (done !== 2'b00) begin
        checks++;
        if (done !== oh(nd)) begin
          errors++;
          $display("FAIL b2b_done %0d: got %b, want %b", nd, done, oh(nd));
        end
        if (nd == 0) t_done0 = t;
        nd++;
      end
    end
    checks++;
    if (nd != 2 || nw != ex.size()) begin
      errors++;
      $display("FAIL b2b_complete: got %0d dones %0d writes, want 2 dones %0d writes", nd, nw, ex.size());
    end
    @(posedge CLOCK_50); #1;
    req = 2'b00;
    @(negedge CLOCK_50);
    m_last = 1;
  endtask

  task automatic test_random();
    int r, x, y, w, h, c;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 1));
      x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 159));
      y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 119));
      w = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, 6));
      c = int'($urandom_range(0, 7));
      exec_cmd("random", r, x, y, w, h, c);
    end
  endtask

  task automatic test_reset_mid_fill();
    int t, nw;
    @(posedge CLOCK_50); #1;
    set_cmd(0, 20, 30, 4, 4, 4);
    req[0] = 1'b1;
    t = 0; nw = 0;
    while (nw < 4 && t < 40) begin
      @(negedge CLOCK_50);
      t++;
      if (we !== 1'b0) nw++;
    end
    checks++;
    if (nw != 4) begin
      errors++;
      $display("FAIL midreset_fill: got %0d writes, want 4 before reset", nw);
    end
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    req[0] = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if (we !== 1'b0 || done !== 2'b00 || busy !== BUSY_AFTER_RESET) begin
      errors++;
      $display("FAIL midreset_stop: got we=%b done=%b busy=%b, want 0 00 %b", we, done, busy, BUSY_AFTER_RESET);
    end
    m_last = 1;
`ifdef FB_CLEAR_ON_RESET_EN
    check_clear(1'b0);
`else
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      checks++;
      if (we !== 1'b0 || done !== 2'b00) begin
        errors++;
        $display("FAIL midreset_quiet: got we=%b done=%b, want 0 00", we, done);
      end
    end
`endif
    exec_cmd("after_reset", 0, 1, 2, 2, 2, 3);
  endtask

  initial begin
    test_reset();
`ifdef FB_CLEAR_ON_RESET_EN
    check_clear(1'b1);
`endif
    test_round_robin();
    exec_cmd("single", 0, 10, 5, 3, 2, 5);
    exec_cmd("clip_partial", 1, 158, 119, 5, 4, 3);
    exec_cmd("clip_empty_x", 0, 200, 10, 10, 3, 6);
    exec_cmd("clip_empty_h", 1, 5, 5, 4, 0, 2);
    exec_cmd("full_width", 0, 0, 7, 255, 1, 7);
    test_back_to_back();
    test_random();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_rect_arbiter.md
Name: fb_rect_arbiter

Overview:
- Write-side controller for the 160x120, 3-bit-colour image RAM.
- Accepts rectangle-fill commands from two requesters, for example the board/tile renderer and the cursor/overlay logic.
- Arbitrates between them round-robin.
- Sequences one pixel write per clock into the RAM write port (we/xw/yw/din) in raster order, clipping each rectangle to the screen.

Parameters:
- SCREEN_W, 160, horizontal pixel count; clip bound for x.
- SCREEN_H, 120, vertical pixel count; clip bound for y.
- CLEAR_COLOR, 3'b000, fill colour for the power-up clear (optional feature only).

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held high until the matching done pulse.
- x0_0, x0_1  in  8 each  rectangle left edge, requester 0/1.
- y0_0, y0_1  in  7 each  rectangle top edge.
- w_0, w_1  in  8 each  rectangle width in pixels (0 = empty).
- h_0, h_1  in  7 each  rectangle height in pixels (0 = empty).
- color_0, color_1  in  3 each  fill colour.
- grant  out  2  one-hot, 1-cycle pulse when a command is accepted.
- done  out  2  one-hot, 1-cycle pulse when the command has finished.
- busy  out  1  high in any state other than IDLE.
- we  out  1  RAM write enable.
- xw  out  8  RAM write x.
- yw  out  7  RAM write y.
- din  out  3  RAM write colour.

Behaviour:
- Reset (synchronous): state=IDLE; grant=0, done=0, busy=0, we=0, xw=0, yw=0, din=0; last_served=1, so requester 0 wins the first tie.
- States: IDLE, FILL, DONE.
- IDLE, no req: hold; we=0.
- IDLE, one req bit set: grant that requester.
- IDLE, both req bits set: grant the requester not equal to last_served.
- On grant:
  - pulse grant[i] for 1 cycle; latch x0, y0, w, h, colour; set last_served=i.
  - clip: w_eff = (x0>=SCREEN_W) ? 0 : min(w, SCREEN_W-x0); h_eff = (y0>=SCREEN_H) ? 0 : min(h, SCREEN_H-y0). Use 9-bit intermediates; no overflow.
  - w_eff=0 or h_eff=0: go to DONE; no RAM writes.
  - otherwise: go to FILL.
- FILL, one write per cycle:
  - we=1, xw=x0+cx, yw=y0+cy, din=colour; cx, cy start at 0.
  - cx increments each cycle; at cx=w_eff-1, cx wraps to 0 and cy increments.
  - after the write at (w_eff-1, h_eff-1), go to DONE.
  - exactly w_eff*h_eff consecutive we cycles.
  - first write occurs the cycle after grant.
- DONE: pulse done[i] for 1 cycle; we=0; go to IDLE.
- Requester handshake:
  - must drop req in the cycle following done.
  - req still high in IDLE is treated as a new command.
  - inputs other than req are don't-care after grant.
- req deasserted mid-FILL: ignored; the command completes and done still pulses.
- A new req arriving during FILL/DONE waits and is arbitrated in IDLE. No request is lost while held.
- Reset mid-FILL: writing stops the next cycle (we=0), state=IDLE, and no done is issued for the aborted command.
- Worst case: a full screen is 19200 write cycles. Two back-to-back commands are separated by at least 2 idle write cycles (DONE, IDLE).

Optional Feature:
- FB_CLEAR_ON_RESET_EN defined:
  - after reset, enter state CLEAR instead of IDLE.
  - CLEAR writes CLEAR_COLOR to every pixel (0,0)..(SCREEN_W-1,SCREEN_H-1) in raster order, one per cycle (19200 cycles).
  - busy=1, grant=0 and done=0 throughout; then go to IDLE.
  - requests are held off, not dropped.
  - reset during CLEAR restarts CLEAR from (0,0).
- Not defined: the CLEAR state and the CLEAR_COLOR logic are absent; reset goes directly to IDLE.

Test Plan:
- Single command: req0 with x0=10, y0=5, w=3, h=2, colour=5.
  - Required: grant[0] pulse, then 6 consecutive we cycles at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6) with din=5.
  - Then done[0] one cycle after the last write; busy falls with IDLE.
- Tie and round-robin: both req high from reset, each w=1, h=1.
  - Required: grant order 0, 1, 0, 1 while both stay asserted.
  - No grant while busy.
- Clipping, partial: x0=158, y0=119, w=5, h=4.
  - Required: exactly 2 writes, at (158,119) and (159,119).
- Clipping, empty: x0=200, w=10; also a separate command with h=0.
  - Required: grant, then done 1 cycle later, with zero we cycles.
- Reset mid-FILL: assert reset on the 4th write of a 4x4 fill.
  - Required: we=0, busy=0 and done=0 the next cycle.
  - A new req0 afterwards is granted normally.
- FB_CLEAR_ON_RESET_EN defined, CLEAR_COLOR=3'b111:
  - Required: 19200 writes of din=7 covering every (x,y) once.
  - req1 held during the clear is granted only after the clear finishes.
